pingpong_writer: RTL and testbench
==================================

# pingpong_writer

Write side of the group double-buffer: sits between the serial word receiver (16-bit `word` plus `ready` strobe) and the two `grpBuffer` RAMs read by the M8 frame former. It aligns on group sync words and strips each data word to its 12-bit payload. It fills one buffer while the frame former reads the other, and hands a buffer over only when the reader has released the previous one. It produces the `bufSwitch` select consumed by the read side and a 5-bit group count.

## Interface
- `WORDS_PER_GRP`, 1024: data words per group; also the buffer depth.
- `ADDR_W`, 10: RAM address width; must satisfy 2^ADDR_W >= WORDS_PER_GRP.
- `SYNC_TAG`, 4'hA: value of `word[15:12]` that marks a group sync word.

Ports:
- `clk`  in  1: system clock, same clock as the receiver and the RAM write port.
- `rst`  in  1: asynchronous, active-high reset.
- `word`  in  16: received word; valid only while `ready` is high.
- `ready`  in  1: single-cycle strobe, at most one every 2 `clk` cycles.
- `rdRelease`  in  1: single-cycle pulse from the read side when it has finished the buffer it holds.
- `outWDAT`  out  12: RAM write data, equal to `word[11:0]`.
- `outWADR`  out  ADDR_W: RAM write address.
- `outWREN`  out  1: RAM write enable.
- `outWSEL`  out  1: buffer being written (0 = m0, 1 = m1).
- `bufSwitch`  out  1: buffer the reader owns; always equal to `~outWSEL`.
- `grpCnt`  out  5: count of committed groups, wraps from 31 to 0.
- `shortGrp`  out  1: one-cycle pulse when a group is aborted by an early sync word.
- `overrun`  out  1: one-cycle pulse when a full group is dropped because the reader still holds the other buffer.

## Operation
- State machine states:
  - HUNT: a sync word (`ready` with `word[15:12]==SYNC_TAG`) sets addr to 0 and moves to FILL. Data words are ignored.
  - FILL: on each data word, write the payload at addr, then increment addr.
    - The write at addr = WORDS_PER_GRP-1 moves to COMMIT.
    - A sync word in FILL pulses `shortGrp`, resets addr to 0 and stays in FILL. The partial data stays in the write buffer and is overwritten.
  - COMMIT (one cycle):
    - If `readerFree`: toggle `outWSEL` (and with it `bufSwitch`), increment `grpCnt`, clear `readerFree`.
    - Otherwise: pulse `overrun`. `outWSEL` is unchanged, so the next group overwrites the same buffer.
    - In both cases, next state is HUNT.
    - A `ready` in the COMMIT cycle is evaluated with HUNT rules.
- `readerFree` flag:
  - Set by `rdRelease`.
  - Cleared by a successful commit.
  - If `rdRelease` and the commit decision fall in the same cycle, the release counts first: the commit succeeds and `readerFree` ends cleared.
- Width rule: the addr counter never exceeds WORDS_PER_GRP-1. `word[15:12]` is discarded for data words.

## Timing
- Reset values: state HUNT, addr 0, `outWREN` 0, `outWDAT` 0, `outWADR` 0, `outWSEL` 0, `bufSwitch` 1, `grpCnt` 0, `shortGrp` 0, `overrun` 0, `readerFree` 1.
- All outputs are registered.
- For a data word with `ready` at cycle N, `outWREN`/`outWADR`/`outWDAT` are valid at N+1 for exactly one cycle.
- The last write of a group is at N+1. COMMIT is cycle N+1, and `outWSEL`/`grpCnt`/`overrun` update at N+2.
- `rst` asserted mid-group discards the group with no write on the following cycles. The buffer contents are left as they are.

## Structure
- Shared package `dtfm_pkg` holds:
  - the `SYNC_TAG` default,
  - the payload width constant 12,
  - the group counter width constant 5,
  - the state enum (HUNT, FILL, COMMIT).
- No sub-module is natural: a single file containing the FSM, the address counter and the ownership flag.

## Test plan
All scenarios use WORDS_PER_GRP=8.
- Reset, then a sync word followed by data words 0x0001..0x0008:
  - RAM 0 receives writes at addresses 0..7 with data 1..8.
  - `outWSEL` goes 0→1 and `bufSwitch` 1→0.
  - `grpCnt`=1.
- Two full groups with no `rdRelease` between them: the second group ends with an `overrun` pulse, `outWSEL` stays 1 and `grpCnt` stays 1.
- The same sequence with `rdRelease` pulsed during the second group: the second commit succeeds, `outWSEL`=0 and `grpCnt`=2.
- Sync word, 3 data words, sync word, 8 data words (tag 0x5):
  - `shortGrp` pulses once.
  - The 8 writes go to addresses 0..7 with the upper nibble stripped.
  - `grpCnt`=1.
- Data words before any sync word: no `outWREN`.
- `rst` asserted after the 4th data word: all outputs return to their reset values. A fresh full group then commits to buffer 0.
- `rdRelease` in the same cycle as COMMIT: the commit succeeds and the next group without a release reports `overrun`.
- 32 committed groups (each with a release): `grpCnt` wraps from 31 to 0.

Source files
------------

// File: rtl/dtfm_pkg.sv
// Shared constants and types for the group double-buffer (DTFM) datapath.
package dtfm_pkg;

    localparam logic [3:0] SYNC_TAG_DEFAULT = 4'hA;
    localparam int         PAYLOAD_W        = 12;
    localparam int         GRP_CNT_W        = 5;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } wr_state_t;

endpackage

// File: rtl/pingpong_writer_if.sv
// Receiver-side inputs and RAM/read-side outputs of the ping-pong group writer.
interface pingpong_writer_if
    import dtfm_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic [15:0]          word;
    logic                 ready;
    logic                 rdRelease;
    logic [PAYLOAD_W-1:0] outWDAT;
    logic [ADDR_W-1:0]    outWADR;
    logic                 outWREN;
    logic                 outWSEL;
    logic                 bufSwitch;
    logic [GRP_CNT_W-1:0] grpCnt;
    logic                 shortGrp;
    logic                 overrun;

    modport master (
        input  word, ready, rdRelease,
        output outWDAT, outWADR, outWREN, outWSEL, bufSwitch, grpCnt, shortGrp, overrun
    );

    modport slave (
        output word, ready, rdRelease,
        input  outWDAT, outWADR, outWREN, outWSEL, bufSwitch, grpCnt, shortGrp, overrun
    );

endinterface

// File: rtl/pingpong_writer.sv
// Write side of the group double-buffer: aligns on sync words, fills one RAM
// while the reader drains the other, and hands over only once it is released.
module pingpong_writer
    import dtfm_pkg::*;
#(
    parameter int         WORDS_PER_GRP = 1024,
    parameter int         ADDR_W        = 10,
    parameter logic [3:0] SYNC_TAG      = SYNC_TAG_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    pingpong_writer_if.master  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_GRP - 1);

    wr_state_t            state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wren_q, wren_d;
    logic [PAYLOAD_W-1:0] wdat_q, wdat_d;
    logic [ADDR_W-1:0]    wadr_q, wadr_d;
    logic                 wsel_q, wsel_d;
    logic                 buf_switch_q, buf_switch_d;
    logic [GRP_CNT_W-1:0] grp_cnt_q, grp_cnt_d;
    logic                 short_q, short_d;
    logic                 overrun_q, overrun_d;
    logic                 reader_free_q, reader_free_d;

    logic is_sync;
    logic is_data;

    assign is_sync = bus.ready && (bus.word[15:12] == SYNC_TAG);
    assign is_data = bus.ready && (bus.word[15:12] != SYNC_TAG);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wren_d    = 1'b0;
        wdat_d    = wdat_q;
        wadr_d    = wadr_q;
        wsel_d    = wsel_q;
        grp_cnt_d = grp_cnt_q;
        short_d   = 1'b0;
        overrun_d = 1'b0;
        // A release arriving in the commit cycle is folded in before the decision.
        reader_free_d = reader_free_q | bus.rdRelease;

        case (state_q)
            FILL: begin
                if (is_sync) begin
                    short_d = 1'b1;
                    addr_d  = '0;
                end else if (is_data) begin
                    wren_d = 1'b1;
                    wadr_d = addr_q;
                    wdat_d = bus.word[PAYLOAD_W-1:0];
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = COMMIT;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            COMMIT: begin
                if (reader_free_d) begin
                    wsel_d        = ~wsel_q;
                    grp_cnt_d     = grp_cnt_q + GRP_CNT_W'(1);
                    reader_free_d = 1'b0;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = HUNT;
                if (is_sync) begin
                    addr_d  = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = HUNT;
                if (is_sync) begin
                    addr_d  = '0;
                    state_d = FILL;
                end
            end
        endcase

        buf_switch_d = ~wsel_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            addr_q        <= '0;
            wren_q        <= 1'b0;
            wdat_q        <= '0;
            wadr_q        <= '0;
            wsel_q        <= 1'b0;
            buf_switch_q  <= 1'b1;
            grp_cnt_q     <= '0;
            short_q       <= 1'b0;
            overrun_q     <= 1'b0;
            reader_free_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wren_q        <= wren_d;
            wdat_q        <= wdat_d;
            wadr_q        <= wadr_d;
            wsel_q        <= wsel_d;
            buf_switch_q  <= buf_switch_d;
            grp_cnt_q     <= grp_cnt_d;
            short_q       <= short_d;
            overrun_q     <= overrun_d;
            reader_free_q <= reader_free_d;
        end
    end

    assign bus.outWREN   = wren_q;
    assign bus.outWDAT   = wdat_q;
    assign bus.outWADR   = wadr_q;
    assign bus.outWSEL   = wsel_q;
    assign bus.bufSwitch = buf_switch_q;
    assign bus.grpCnt    = grp_cnt_q;
    assign bus.shortGrp  = short_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_pingpong_writer.sv
// Scoreboard bench for pingpong_writer with 8-word groups and a group-level model.
`timescale 1ns/1ps
module tb_pingpong_writer;

    localparam int WPG = 8;
    localparam int AW  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] word = 16'h0000;
    logic        ready = 1'b0;
    logic        rd_release = 1'b0;

    int checks = 0;
    int failures = 0;

    // expected writes: {sel, addr[2:0], data[11:0]}
    logic [15:0] sb[$];

    int  short_seen = 0;
    int  ovr_seen = 0;
    int  exp_short = 0;
    int  exp_ovr = 0;
    bit  m_fill = 1'b0;
    int  m_addr = 0;
    bit  m_sel = 1'b0;
    bit  m_free = 1'b1;
    int  m_cnt = 0;

    pingpong_writer_if #(.ADDR_W(AW)) bus ();

    assign bus.word      = word;
    assign bus.ready     = ready;
    assign bus.rdRelease = rd_release;

    pingpong_writer #(
        .WORDS_PER_GRP(WPG),
        .ADDR_W(AW),
        .SYNC_TAG(4'hA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.outWREN) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_write", {16'h0, bus.outWSEL, bus.outWADR, bus.outWDAT}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("write", {16'h0, bus.outWSEL, bus.outWADR, bus.outWDAT}, {16'h0, sb.pop_front()});
                end
            end
            if (bus.shortGrp) short_seen++;
            if (bus.overrun)  ovr_seen++;
        end
    end

    task automatic modelCommit(input bit rel);
        if (m_free || rel) begin
            m_sel  = ~m_sel;
            m_cnt  = (m_cnt + 1) % 32;
            m_free = 1'b0;
        end else begin
            exp_ovr++;
        end
    endtask

    // One word strobe; rel pulses rdRelease in the cycle after the strobe.
    task automatic applyStimulus(input logic [15:0] w, input bit rel);
        bit sync;
        bit committed;
        sync = (w[15:12] == 4'hA);
        committed = 1'b0;
        @(negedge clk);
        word = w;
        ready = 1'b1;
        rd_release = 1'b0;
        if (m_fill) begin
            if (sync) begin
                exp_short++;
                m_addr = 0;
            end else begin
                sb.push_back({m_sel, 3'(m_addr), w[11:0]});
                if (m_addr == WPG - 1) begin
                    m_fill = 1'b0;
                    m_addr = 0;
                    modelCommit(rel);
                    committed = 1'b1;
                end else begin
                    m_addr++;
                end
            end
        end else if (sync) begin
            m_fill = 1'b1;
            m_addr = 0;
        end
        if (!committed && rel) m_free = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        rd_release = rel;
        @(negedge clk);
        rd_release = 1'b0;
    endtask

    task automatic sendGroup(input logic [3:0] tag, input int rel_idx);
        applyStimulus(16'hA000, 1'b0);
        for (int i = 1; i <= WPG; i++)
            applyStimulus({tag, 12'(i)}, i == rel_idx);
    endtask

    task automatic checkState(input string tag);
        repeat (2) @(negedge clk);
        #1;
        checkOutput({tag, "_sel"}, {31'h0, bus.outWSEL}, {31'h0, m_sel});
        checkOutput({tag, "_bufsw"}, {31'h0, bus.bufSwitch}, {31'h0, ~m_sel});
        checkOutput({tag, "_cnt"}, {27'h0, bus.grpCnt}, 32'(m_cnt));
        checkOutput({tag, "_short"}, 32'(short_seen), 32'(exp_short));
        checkOutput({tag, "_ovr"}, 32'(ovr_seen), 32'(exp_ovr));
        checkOutput({tag, "_pending"}, 32'(sb.size()), 32'h0);
    endtask

    task automatic doReset(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        ready = 1'b0;
        rd_release = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_rst_wren"}, {31'h0, bus.outWREN}, 32'h0);
        checkOutput({tag, "_rst_wdat"}, {20'h0, bus.outWDAT}, 32'h0);
        checkOutput({tag, "_rst_wadr"}, {29'h0, bus.outWADR}, 32'h0);
        checkOutput({tag, "_rst_wsel"}, {31'h0, bus.outWSEL}, 32'h0);
        checkOutput({tag, "_rst_bufsw"}, {31'h0, bus.bufSwitch}, 32'h1);
        checkOutput({tag, "_rst_cnt"}, {27'h0, bus.grpCnt}, 32'h0);
        checkOutput({tag, "_rst_short"}, {31'h0, bus.shortGrp}, 32'h0);
        checkOutput({tag, "_rst_ovr"}, {31'h0, bus.overrun}, 32'h0);
        checkOutput({tag, "_rst_pending"}, 32'(sb.size()), 32'h0);
        m_fill = 1'b0;
        m_addr = 0;
        m_sel = 1'b0;
        m_free = 1'b1;
        m_cnt = 0;
        exp_short = short_seen;
        exp_ovr = ovr_seen;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset("t1");
        sendGroup(4'h0, 0);
        checkState("t1_group");

        doReset("t2");
        sendGroup(4'h0, 0);
        sendGroup(4'h1, 0);
        checkState("t2_overrun");

        doReset("t3");
        sendGroup(4'h0, 0);
        sendGroup(4'h2, 4);
        checkState("t3_release");

        doReset("t4");
        applyStimulus(16'hA000, 1'b0);
        for (int i = 1; i <= 3; i++) applyStimulus(16'h0F00 + 16'(i), 1'b0);
        sendGroup(4'h5, 0);
        checkState("t4_short");

        doReset("t5");
        applyStimulus(16'h0123, 1'b0);
        applyStimulus(16'h5456, 1'b0);
        applyStimulus(16'hF789, 1'b0);
        checkState("t5_nosync");

        doReset("t6");
        applyStimulus(16'hA000, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(16'h0030 + 16'(i), 1'b0);
        doReset("t6_mid");
        sendGroup(4'h6, 0);
        checkState("t6_fresh");

        doReset("t7");
        sendGroup(4'h0, WPG);
        checkState("t7_commit_rel");
        sendGroup(4'h7, 0);
        checkState("t7_overrun");

        doReset("t8");
        for (int g = 0; g < 31; g++) sendGroup(4'(g % 8), WPG);
        checkState("t8_31");
        sendGroup(4'h3, WPG);
        checkState("t8_wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
